// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin multi-requester write port into a flip-flop FIFO
// Optional FIFO_ARB_SRC_ID_EN stores the granted index per entry and exposes it as out_src.
module fifo_rr_arbiter #(
  parameter int width = 8,
  parameter int depth = 10,
  parameter int n_req = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [n_req-1:0]               in_valid,
  input  logic [n_req*width-1:0]         in_data,
  output logic [n_req-1:0]               in_ready,
  output logic                           out_valid,
  output logic [width-1:0]               out_data,
  input  logic                           out_ready,
  output logic                           empty,
  output logic                           full
`ifdef FIFO_ARB_SRC_ID_EN
  ,
  output logic [$clog2(n_req)-1:0]       out_src
`endif
);

  localparam int aw = $clog2(depth);
  localparam int sw = $clog2(n_req);

  logic [width-1:0] mem [depth];
`ifdef FIFO_ARB_SRC_ID_EN
  logic [sw-1:0]    src_mem [depth];
`endif

  logic [aw-1:0] wr_ptr, rd_ptr;
  logic          wr_circ, rd_circ;
  logic [sw-1:0] last_grant;
  logic [sw-1:0] grant_idx;
  logic          grant_valid;
  logic          push, pop;

  function automatic logic [sw-1:0] rr_idx(input logic [sw-1:0] lg, input int k);
    int t;
    t = int'(lg) + k;
    if (t >= n_req) t = t - n_req;
    return t[sw-1:0];
  endfunction

  // Search begins one past the last accepted requester so every requester gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= n_req; k++) begin
      if (!grant_valid && in_valid[rr_idx(last_grant, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_idx(last_grant, k);
      end
    end
  end

  assign empty     = (wr_ptr == rd_ptr) && (wr_circ == rd_circ);
  assign full      = (wr_ptr == rd_ptr) && (wr_circ != rd_circ);
  assign in_ready  = (grant_valid && !full && !rst) ? (n_req'(1) << grant_idx) : '0;
  assign push      = |(in_valid & in_ready);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];
`ifdef FIFO_ARB_SRC_ID_EN
  assign out_src   = src_mem[rd_ptr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_circ    <= 1'b0;
      rd_ptr     <= '0;
      rd_circ    <= 1'b0;
      last_grant <= sw'(n_req - 1);
    end else begin
      if (push) begin
        last_grant <= grant_idx;
        if (wr_ptr == aw'(depth - 1)) begin
          wr_ptr  <= '0;
          wr_circ <= ~wr_circ;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (pop) begin
        if (rd_ptr == aw'(depth - 1)) begin
          rd_ptr  <= '0;
          rd_circ <= ~rd_circ;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data[grant_idx*width +: width];
`ifdef FIFO_ARB_SRC_ID_EN
      src_mem[wr_ptr] <= grant_idx;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed vector bench for fifo_rr_arbiter (default parameters)
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        empty;
  logic        full;
`ifdef FIFO_ARB_SRC_ID_EN
  logic [1:0]  out_src;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.width(8), .depth(10), .n_req(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .empty(empty), .full(full)
`ifdef FIFO_ARB_SRC_ID_EN
    , .out_src(out_src)
`endif
  );

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] er;
    logic       eov;
    logic [7:0] ed;
    logic       chkd;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1; inputs applied, combinational/registered outputs checked at negedge.
  task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] er,
                      input logic eov, input logic efull, input logic [7:0] ed, input logic chkd);
    in_valid  = v;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", {28'd0, in_ready}, {28'd0, er});
    chk("out_valid", {31'd0, out_valid}, {31'd0, eov});
    chk("empty", {31'd0, empty}, {31'd0, ~eov});
    chk("full", {31'd0, full}, {31'd0, efull});
    if (chkd) chk("out_data", {24'd0, out_data}, {24'd0, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA0, 1'b1};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA0, 1'b1};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA0, 1'b1};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA0, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA1, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA2, 1'b1};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA3, 1'b1};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 8'hA0, 1'b1};
    vecs[12] = '{4'b0101, 1'b0, 4'b0001, 1'b1, 8'hA0, 1'b1};
    vecs[13] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'hA0, 1'b1};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA2, 1'b1};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA0, 1'b1};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA3, 1'b1};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};

    // Grant order from reset, drain order, rotation with sparse requesters.
    do_reset();
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 18; i++)
      step(vecs[i].v, vecs[i].ordy, vecs[i].er, vecs[i].eov, 1'b0, vecs[i].ed, vecs[i].chkd);

    // Single requester from reset; last_grant ends at 2 so requester 3 is next.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(4'b0100, 1'b0, 4'b0100, (i != 0), 1'b0, 8'hA2, (i != 0));
    step(4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 8'hA2, 1'b1);

    // Fill to full, pop while full blocks push, push resumes next cycle, ordered drain.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      in_data = {4{8'(k)}};
      step(4'b0001, 1'b0, 4'b0001, (k != 0), 1'b0, 8'd0, (k != 0));
    end
    in_data = {4{8'd10}};
    step(4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1, 8'd0, 1'b1);
    step(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 8'd1, 1'b1);
    for (int k = 1; k <= 10; k++)
      step(4'b0000, 1'b1, 4'b0000, 1'b1, (k == 1), 8'(k), 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0, 1'b0);

    // Steady push+pop at occupancy 5 across two pointer wraps.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_data = {4{8'(k)}};
      step(4'b0010, 1'b0, 4'b0010, (k != 0), 1'b0, 8'd0, (k != 0));
    end
    for (int k = 0; k < 20; k++) begin
      in_data = {4{8'(k + 5)}};
      step(4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, 8'(k), 1'b1);
    end
    for (int k = 20; k < 25; k++)
      step(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 8'(k), 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0, 1'b0);

    // Asynchronous reset with 7 entries held.
    do_reset();
    in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int k = 0; k < 7; k++)
      step(4'b1110, 1'b0, (4'b0010 << (k % 3)), (k != 0), 1'b0, 8'hD1, (k != 0));
    in_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 8'd0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hD0, 1'b1);

`ifdef FIFO_ARB_SRC_ID_EN
    do_reset();
    in_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    for (int k = 0; k < 4; k++)
      step(4'b1010, 1'b0, (k % 2 == 0) ? 4'b0010 : 4'b1000, (k != 0), 1'b0, 8'hB1, (k != 0));
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      in_valid = '0;
      @(negedge clk);
      chk("out_src", {30'd0, out_src}, (k % 2 == 0) ? 32'd1 : 32'd3);
      chk("src_data", {24'd0, out_data}, (k % 2 == 0) ? 32'hB1 : 32'hB3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter width, default 8: data bits per entry.
REQ-002 Parameter depth, default 10: FIFO entries, any value >= 2, not necessarily a power of two.
REQ-003 Parameter n_req, default 4: number of requesters, 2..16.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  n_req  per-requester write request.
REQ-007 in_data  input  n_req*width  requester i data in bits [i*width +: width].
REQ-008 in_ready  output  n_req  one-hot-or-zero grant; transfer for requester i when in_valid[i] & in_ready[i].
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_data  output  width  head entry.
REQ-011 out_ready  input  1  consumer accept; pop when out_valid & out_ready.
REQ-012 empty  output  1  no stored entries.
REQ-013 full  output  1  depth entries stored.
REQ-014 out_src  output  $clog2(n_req)  source index of head entry; present only with FIFO_ARB_SRC_ID_EN.

Function
REQ-015 Storage SHALL be a flip-flop circular buffer with wr_ptr/rd_ptr wrapping from depth-1 to 0, each with a circle bit toggling on wrap.
REQ-016 empty SHALL equal (wr_ptr == rd_ptr) & same circle; full SHALL equal (wr_ptr == rd_ptr) & different circle.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo n_req and grants the first index with in_valid set.
REQ-018 in_ready SHALL be all-zero when full, even if out_ready pops in the same cycle.
REQ-019 in_ready SHALL be combinational from in_valid, last_grant and full; at most one bit SHALL be high.
REQ-020 last_grant SHALL update to the granted index only on an accepted transfer; with no transfer it SHALL hold.
REQ-021 An accepted transfer SHALL write in_data of the granted requester at wr_ptr and advance wr_ptr on that edge.
REQ-022 out_valid SHALL equal ~empty; out_data SHALL be combinational from the entry at rd_ptr.
REQ-023 A pop SHALL advance rd_ptr; out_ready while empty SHALL have no effect.
REQ-024 Push-to-out_valid latency SHALL be one cycle; an entry written at edge N SHALL be visible after edge N.
REQ-025 When not full and not empty, a simultaneous push and pop SHALL both take effect, leaving occupancy unchanged.
REQ-026 Entries SHALL be read in acceptance order regardless of source.
REQ-027 A requester that drops in_valid before a grant SHALL lose nothing; the arbiter does not require valid to be held.

Reset
REQ-028 On rst SHALL be: wr_ptr = rd_ptr = 0, both circle bits 0, last_grant = n_req-1, empty = 1, full = 0, out_valid = 0, in_ready = 0 while asserted.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries immediately; the data array itself is not reset.
REQ-030 After rst deasserts, requester 0 SHALL have highest priority on the first grant.

Configuration
REQ-031 With macro FIFO_ARB_SRC_ID_EN defined, each entry SHALL store the granted index alongside data, and out_src SHALL show the head entry's source.
REQ-032 Without FIFO_ARB_SRC_ID_EN, out_src and its storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then in_valid=4'b1111 for 4 cycles with out_ready=0 -> grants in order 0,1,2,3, and out_data pops give in_data of 0,1,2,3.
REQ-034 depth=10 and 10 accepted pushes -> full=1, in_ready=0; one pop with in_valid high -> no push in that cycle, and a push the next cycle.
REQ-035 Only in_valid[2] high for 3 cycles from reset -> in_ready=4'b0100 each cycle, and last_grant=2.
REQ-036 Fill to 5 entries, then simultaneous push and pop for 20 cycles -> occupancy stays 5, pointers wrap past 9, data order is preserved.
REQ-037 rst pulsed with 7 entries stored -> empty=1 and out_valid=0 the same cycle, and the next grant goes to requester 0.
REQ-038 With FIFO_ARB_SRC_ID_EN and in_valid=4'b1010 -> out_src sequence 1,3,1,3 matches grants.
